// File: rtl/btb_update_queue.sv
// Circular queue of BTB updates from resolving branches. Same-cycle duplicate
// PCs collapse, updates that match a queued entry coalesce in place, and the
// head is presented to the BTB write port.
module btb_update_queue #(
    parameter int NUM_REQ = 2,
    parameter int DEPTH   = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0][31:0]     req_branch_pc,
    input  logic [NUM_REQ-1:0][31:0]     req_target_pc,
    output logic                         req_ready,
    output logic                         wr_valid,
    output logic [31:0]                  wr_branch_pc,
    output logic [31:0]                  wr_target_pc,
    input  logic                         wr_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - NUM_REQ);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [31:0]      pc_q [DEPTH];
    logic [31:0]      pc_d [DEPTH];
    logic [31:0]      tgt_q[DEPTH];
    logic [31:0]      tgt_d[DEPTH];
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;

    logic             deq;
    logic [NUM_REQ-1:0] survive, hit;
    logic [PW-1:0]    slot;
    logic [CW-1:0]    n_alloc;

    // Handshakes: a request set transfers on any edge where req_ready is high
    // (all asserted requesters at once); the head transfers on wr_valid && wr_ready.
    // req_ready depends only on registered count, so requesters may hold safely.
    assign req_ready    = (count_q <= READY_MAX);
    assign wr_valid     = (count_q != '0);
    assign wr_branch_pc = wr_valid ? pc_q[head_q]  : 32'h0;
    assign wr_target_pc = wr_valid ? tgt_q[head_q] : 32'h0;
    assign count        = count_q;
    assign deq          = wr_valid && wr_ready;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        head_d  = head_q;
        survive = '0;
        hit     = '0;
        slot    = tail_q;
        n_alloc = '0;

        if (deq) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end

        if (req_ready) begin
            // Only the highest-indexed requester of a same-PC group survives.
            for (int i = 0; i < NUM_REQ; i++) begin
                survive[i] = req_valid[i];
                for (int j = i + 1; j < NUM_REQ; j++) begin
                    if (req_valid[j] && (req_branch_pc[j] == req_branch_pc[i])) begin
                        survive[i] = 1'b0;
                    end
                end
            end

            for (int i = 0; i < NUM_REQ; i++) begin
                if (survive[i]) begin
                    // A head leaving this cycle cannot absorb the update.
                    for (int k = 0; k < DEPTH; k++) begin
                        if (valid_q[k] && !(deq && (PW'(k) == head_q)) &&
                            (pc_q[k] == req_branch_pc[i])) begin
                            tgt_d[k] = req_target_pc[i];
                            hit[i]   = 1'b1;
                        end
                    end
                    if (!hit[i]) begin
                        valid_d[slot] = 1'b1;
                        pc_d[slot]    = req_branch_pc[i];
                        tgt_d[slot]   = req_target_pc[i];
                        slot          = slot + 1'b1;
                        n_alloc       = n_alloc + 1'b1;
                    end
                end
            end
        end

        tail_d  = slot;
        count_d = count_q + n_alloc - CW'(deq);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                pc_q[k]  <= '0;
                tgt_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
        end
    end

endmodule

// File: tb/tb_btb_update_queue.sv
// Bench for btb_update_queue: directed vector table, randomized traffic
// against a queue model, and a mid-operation reset with wrapped pointers.
module tb_btb_update_queue;

    localparam int NUM_REQ = 2;
    localparam int DEPTH   = 4;

    logic                     clock;
    logic                     reset;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0][31:0] req_branch_pc;
    logic [NUM_REQ-1:0][31:0] req_target_pc;
    logic                     req_ready;
    logic                     wr_valid;
    logic [31:0]              wr_branch_pc;
    logic [31:0]              wr_target_pc;
    logic                     wr_ready;
    logic [2:0]               count;

    int checks   = 0;
    int failures = 0;

    logic [63:0] exp_q[$];

    typedef struct {
        logic [1:0]  v;
        logic [31:0] p0, t0, p1, t1;
        logic        wr;
        logic        e_wv;
        logic [31:0] e_pc, e_tgt;
        logic [2:0]  e_cnt;
        logic        e_rdy;
    } vec_t;

    vec_t vecs[$];

    btb_update_queue #(.NUM_REQ(NUM_REQ), .DEPTH(DEPTH)) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_branch_pc (req_branch_pc),
        .req_target_pc (req_target_pc),
        .req_ready     (req_ready),
        .wr_valid      (wr_valid),
        .wr_branch_pc  (wr_branch_pc),
        .wr_target_pc  (wr_target_pc),
        .wr_ready      (wr_ready),
        .count         (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Drive one cycle; the model predicts status, scores the dequeued head,
    // then applies collapse/coalesce/allocate to the expected queue.
    task automatic step(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] t0,
                        input logic [31:0] p1, input logic [31:0] t1, input logic wr);
        logic [31:0] pcs[2];
        logic [31:0] tgs[2];
        logic [63:0] e;
        logic        rdy_m;
        logic        surv;
        logic        found;
        req_valid     = v;
        req_branch_pc = {p1, p0};
        req_target_pc = {t1, t0};
        wr_ready      = wr;
        pcs = '{p0, p1};
        tgs = '{t0, t1};
        #1;
        rdy_m = (exp_q.size() <= DEPTH - NUM_REQ);
        check("count", 32'(count), 32'(exp_q.size()));
        check("req_ready", 32'(req_ready), 32'(rdy_m));
        check("wr_valid", 32'(wr_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() > 0 && wr) begin
            e = exp_q.pop_front();
            check("sb_pc", wr_branch_pc, e[63:32]);
            check("sb_tgt", wr_target_pc, e[31:0]);
        end
        if (rdy_m) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                surv = v[i] && !(i == 0 && v[1] && (p1 == p0));
                if (surv) begin
                    found = 1'b0;
                    for (int k = 0; k < exp_q.size(); k++) begin
                        if (exp_q[k][63:32] == pcs[i]) begin
                            exp_q[k][31:0] = tgs[i];
                            found = 1'b1;
                        end
                    end
                    if (!found) exp_q.push_back({pcs[i], tgs[i]});
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        vec_t r;
        // v, p0, t0, p1, t1, wr | wr_valid, wr_pc, wr_tgt, count, req_ready (after the edge)
        vecs.push_back('{2'b01, 32'h100, 32'h200, 32'h0,  32'h0,  1'b1, 1'b1, 32'h100, 32'h200, 3'd1, 1'b1});
        vecs.push_back('{2'b00, 32'h0,   32'h0,   32'h0,  32'h0,  1'b1, 1'b0, 32'h0,   32'h0,   3'd0, 1'b1});
        vecs.push_back('{2'b11, 32'h10,  32'h11,  32'h20, 32'h21, 1'b0, 1'b1, 32'h10,  32'h11,  3'd2, 1'b1});
        vecs.push_back('{2'b11, 32'h30,  32'h31,  32'h40, 32'h41, 1'b0, 1'b1, 32'h10,  32'h11,  3'd4, 1'b0});
        vecs.push_back('{2'b01, 32'h50,  32'h51,  32'h0,  32'h0,  1'b0, 1'b1, 32'h10,  32'h11,  3'd4, 1'b0});
        vecs.push_back('{2'b00, 32'h0,   32'h0,   32'h0,  32'h0,  1'b1, 1'b1, 32'h20,  32'h21,  3'd3, 1'b0});
        vecs.push_back('{2'b00, 32'h0,   32'h0,   32'h0,  32'h0,  1'b1, 1'b1, 32'h30,  32'h31,  3'd2, 1'b1});
        vecs.push_back('{2'b00, 32'h0,   32'h0,   32'h0,  32'h0,  1'b1, 1'b1, 32'h40,  32'h41,  3'd1, 1'b1});
        vecs.push_back('{2'b00, 32'h0,   32'h0,   32'h0,  32'h0,  1'b1, 1'b0, 32'h0,   32'h0,   3'd0, 1'b1});
        vecs.push_back('{2'b11, 32'h80,  32'hA0,  32'h80, 32'hB0, 1'b0, 1'b1, 32'h80,  32'hB0,  3'd1, 1'b1});
        vecs.push_back('{2'b00, 32'h0,   32'h0,   32'h0,  32'h0,  1'b1, 1'b0, 32'h0,   32'h0,   3'd0, 1'b1});
        vecs.push_back('{2'b11, 32'h60,  32'h61,  32'h80, 32'hA0, 1'b0, 1'b1, 32'h60,  32'h61,  3'd2, 1'b1});
        vecs.push_back('{2'b01, 32'h80,  32'hC0,  32'h0,  32'h0,  1'b0, 1'b1, 32'h60,  32'h61,  3'd2, 1'b1});
        vecs.push_back('{2'b00, 32'h0,   32'h0,   32'h0,  32'h0,  1'b1, 1'b1, 32'h80,  32'hC0,  3'd1, 1'b1});
        vecs.push_back('{2'b01, 32'h80,  32'hD0,  32'h0,  32'h0,  1'b1, 1'b1, 32'h80,  32'hD0,  3'd1, 1'b1});
        vecs.push_back('{2'b01, 32'h80,  32'hE0,  32'h0,  32'h0,  1'b0, 1'b1, 32'h80,  32'hE0,  3'd1, 1'b1});
        vecs.push_back('{2'b10, 32'h0,   32'h0,   32'h90, 32'h91, 1'b1, 1'b1, 32'h90,  32'h91,  3'd1, 1'b1});
        vecs.push_back('{2'b00, 32'h0,   32'h0,   32'h0,  32'h0,  1'b1, 1'b0, 32'h0,   32'h0,   3'd0, 1'b1});

        reset         = 1'b1;
        req_valid     = '0;
        req_branch_pc = '0;
        req_target_pc = '0;
        wr_ready      = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_wr_valid", 32'(wr_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_wr_pc", wr_branch_pc, 32'h0);
        check("rst_wr_tgt", wr_target_pc, 32'h0);
        reset = 1'b0;

        for (int n = 0; n < vecs.size(); n++) begin
            r = vecs[n];
            step(r.v, r.p0, r.t0, r.p1, r.t1, r.wr);
            check($sformatf("vec%0d_wr_valid", n), 32'(wr_valid), 32'(r.e_wv));
            check($sformatf("vec%0d_wr_pc", n), wr_branch_pc, r.e_pc);
            check($sformatf("vec%0d_wr_tgt", n), wr_target_pc, r.e_tgt);
            check($sformatf("vec%0d_count", n), 32'(count), 32'(r.e_cnt));
            check($sformatf("vec%0d_req_ready", n), 32'(req_ready), 32'(r.e_rdy));
        end

        // Random traffic over a small PC pool to provoke collapse and coalesce.
        for (int n = 0; n < 300; n++) begin
            step(2'($urandom_range(0, 3)),
                 32'h100 + 32'($urandom_range(0, 5)) * 4, $urandom,
                 32'h100 + 32'($urandom_range(0, 5)) * 4, $urandom,
                 1'($urandom_range(0, 1)));
        end

        // Fresh reset, then build count=3 with head=2 and tail wrapped to 1.
        reset     = 1'b1;
        req_valid = '0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        exp_q.delete();
        step(2'b01, 32'hA00, 32'hA01, 32'h0,   32'h0,   1'b0);
        step(2'b11, 32'hB00, 32'hB01, 32'hC00, 32'hC01, 1'b1);
        step(2'b11, 32'hD00, 32'hD01, 32'hE00, 32'hE01, 1'b1);
        check("wrap_count", 32'(count), 32'd3);
        check("wrap_head_pc", wr_branch_pc, 32'hC00);

        // Requests presented during the reset cycle must be dropped.
        reset         = 1'b1;
        req_valid     = 2'b11;
        req_branch_pc = {32'h600, 32'h500};
        req_target_pc = {32'h601, 32'h501};
        wr_ready      = 1'b1;
        @(posedge clock);
        #1;
        check("mid_rst_wr_valid", 32'(wr_valid), 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_req_ready", 32'(req_ready), 32'd1);
        check("mid_rst_wr_pc", wr_branch_pc, 32'h0);
        reset = 1'b0;
        exp_q.delete();
        step(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        check("post_rst_count", 32'(count), 32'd0);
        check("post_rst_wr_valid", 32'(wr_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
